decode_issue_ctrl: RTL and testbench

- Issue controller between fetch and the Decode stage.
- Tracks pending register writes in a 16-entry scoreboard and stalls fetch/decode on RAW/WAW hazards.
- Sequences the multi-cycle multiplier and squashes decode after an execute-stage branch redirect.
- Also handles the HALT instruction, holding the pipe until resumed.

---
 rtl/decode_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// Decode issue controller: scoreboard hazards, multiplier sequencing,
// redirect squash and HALT hold between fetch and decode.
module decode_issue_ctrl #(
    parameter logic [4:0] OP_BRANCH = 5'h10,
    parameter logic [4:0] OP_STORE  = 5'h0F,
    parameter logic [4:0] OP_MUL    = 5'h03,
    parameter logic [4:0] OP_HALT   = 5'h1F,
    parameter int         MUL_LAT   = 4,
    parameter int         FLUSH_LEN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  opcode,
    input  logic        immediate_bit,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd,
    input  logic        ex_redirect,
    input  logic        resume,
    output logic        id_issue,
    output logic        fetch_stall,
    output logic        dec_flush,
    output logic        halted,
    output logic [15:0] busy_vec
);

    localparam int MW = $clog2(MUL_LAT + 1);
    localparam int FW = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [MW-1:0] mul_cnt;
    logic [FW-1:0] flush_cnt;
    logic [FW-1:0] flush_nxt;

    logic        uses_rs1;
    logic        uses_rs2;
    logic        reads_rd;
    logic        writes_rd;
    logic        is_mul;
    logic [15:0] wb_mask;
    logic [15:0] set_mask;
    logic [15:0] eff;
    logic        hazard;

    logic        issue_c;
    logic        stall_c;
    logic        flush_c;
    logic        halted_c;

    assign uses_rs1  = opcode != OP_BRANCH;
    assign uses_rs2  = !immediate_bit && opcode != OP_BRANCH;
    assign reads_rd  = opcode == OP_STORE;
    assign writes_rd = opcode != OP_BRANCH && opcode != OP_STORE
                    && opcode != OP_HALT;
    assign is_mul    = opcode == OP_MUL;

    // Register file is write-first, so a same-cycle writeback unblocks.
    assign wb_mask = wb_valid ? (16'h0001 << wb_rd) : 16'h0000;
    assign eff     = busy_vec & ~wb_mask;

    assign hazard = id_valid && (
                        (uses_rs1  && eff[rs1])
                     || (uses_rs2  && eff[rs2])
                     || (reads_rd  && eff[rd])
                     || (writes_rd && eff[rd])
                     || (is_mul    && mul_cnt != '0));

    always_comb begin
        issue_c   = 1'b0;
        stall_c   = 1'b0;
        flush_c   = 1'b0;
        halted_c  = 1'b0;
        state_nxt = state;
        flush_nxt = flush_cnt;
        unique case (state)
            RUN: begin
                if (ex_redirect) begin
                    flush_c   = 1'b1;
                    flush_nxt = FW'(FLUSH_LEN);
                    state_nxt = FLUSH;
                end else if (hazard) begin
                    stall_c = 1'b1;
                end else begin
                    issue_c = id_valid;
                    if (id_valid && opcode == OP_HALT)
                        state_nxt = HALT;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (ex_redirect) begin
                    flush_nxt = FW'(FLUSH_LEN);
                end else begin
                    flush_nxt = flush_cnt - FW'(1);
                    if (flush_cnt <= FW'(1))
                        state_nxt = RUN;
                end
            end
            HALT: begin
                halted_c = 1'b1;
                stall_c  = 1'b1;
                if (resume)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // All outputs are forced low while reset is held.
    assign id_issue    = rst_n & issue_c;
    assign fetch_stall = rst_n & stall_c;
    assign dec_flush   = rst_n & flush_c;
    assign halted      = rst_n & halted_c;

    assign set_mask = (id_issue && writes_rd) ? (16'h0001 << rd) : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= '0;
            mul_cnt   <= '0;
            busy_vec  <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
            busy_vec  <= (busy_vec & ~wb_mask) | set_mask;
            if (id_issue && is_mul)
                mul_cnt <= MW'(MUL_LAT);
            else if (mul_cnt != '0)
                mul_cnt <= mul_cnt - MW'(1);
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: directed steps queue their
// expected outputs, a negedge monitor pops and compares.
module tb_decode_issue_ctrl;

    localparam logic [4:0] ADD = 5'h01;
    localparam logic [4:0] STO = 5'h0F;
    localparam logic [4:0] MUL = 5'h03;
    localparam logic [4:0] BRA = 5'h10;
    localparam logic [4:0] HLT = 5'h1F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  opcode = '0;
    logic        immediate_bit = 1'b0;
    logic [3:0]  rd = '0;
    logic [3:0]  rs1 = '0;
    logic [3:0]  rs2 = '0;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_rd = '0;
    logic        ex_redirect = 1'b0;
    logic        resume = 1'b0;
    logic        id_issue;
    logic        fetch_stall;
    logic        dec_flush;
    logic        halted;
    logic [15:0] busy_vec;

    decode_issue_ctrl #(
        .MUL_LAT   (4),
        .FLUSH_LEN (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .opcode        (opcode),
        .immediate_bit (immediate_bit),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .ex_redirect   (ex_redirect),
        .resume        (resume),
        .id_issue      (id_issue),
        .fetch_stall   (fetch_stall),
        .dec_flush     (dec_flush),
        .halted        (halted),
        .busy_vec      (busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [3:0]  o;
        logic [15:0] b;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   passed = 0;

    // o = {id_issue, fetch_stall, dec_flush, halted}
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            logic [3:0] act;
            e   = expq.pop_front();
            act = {id_issue, fetch_stall, dec_flush, halted};
            checks++;
            if (act === e.o) passed++;
            else $display("FAIL %s outs: got %b want %b", e.nm, act, e.o);
            checks++;
            if (busy_vec === e.b) passed++;
            else $display("FAIL %s busy_vec: got %h want %h",
                          e.nm, busy_vec, e.b);
        end
    end

    task automatic step(
        input string      nm,
        input logic       r,
        input logic       v,
        input logic [4:0] op,
        input logic       im,
        input logic [3:0] d,
        input logic [3:0] s1,
        input logic [3:0] s2,
        input logic       wv,
        input logic [3:0] wr,
        input logic       rdr,
        input logic       res,
        input logic [3:0] eo,
        input logic [15:0] eb
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_n         = r;
        id_valid      = v;
        opcode        = op;
        immediate_bit = im;
        rd            = d;
        rs1           = s1;
        rs2           = s2;
        wb_valid      = wv;
        wb_rd         = wr;
        ex_redirect   = rdr;
        resume        = res;
        e.nm = nm;
        e.o  = eo;
        e.b  = eb;
        expq.push_back(e);
    endtask

    initial begin
        //   name          r v op  im d  s1 s2 wv wr rd rs  outs     busy
        step("rst",        0,1,ADD,0, 3, 1, 2, 0, 0, 0, 0, 4'b0000, 16'h0000);
        step("add1",       1,1,ADD,0, 3, 1, 2, 0, 0, 0, 0, 4'b1000, 16'h0000);
        step("raw_stall1", 1,1,ADD,0, 4, 3, 5, 0, 0, 0, 0, 4'b0100, 16'h0008);
        step("raw_stall2", 1,1,ADD,0, 4, 3, 5, 0, 0, 0, 0, 4'b0100, 16'h0008);
        step("raw_wb",     1,1,ADD,0, 4, 3, 5, 1, 3, 0, 0, 4'b1000, 16'h0008);
        step("after_wb",   1,0,ADD,0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 16'h0010);
        step("add3",       1,1,ADD,0, 3, 1, 2, 0, 0, 0, 0, 4'b1000, 16'h0010);
        step("imm_rs2",    1,1,ADD,1, 5, 1, 3, 0, 0, 0, 0, 4'b1000, 16'h0018);
        step("store_rd",   1,1,STO,1, 3, 1, 0, 0, 0, 0, 0, 4'b0100, 16'h0038);
        step("store_wb",   1,1,STO,1, 3, 1, 0, 1, 3, 0, 0, 4'b1000, 16'h0038);
        step("wb4",        1,0,ADD,0, 0, 0, 0, 1, 4, 0, 0, 4'b0000, 16'h0030);
        step("wb5",        1,0,ADD,0, 0, 0, 0, 1, 5, 0, 0, 4'b0000, 16'h0020);
        step("mul6",       1,1,MUL,0, 6, 1, 2, 0, 0, 0, 0, 4'b1000, 16'h0000);
        step("mul7_st1",   1,1,MUL,0, 7, 1, 2, 0, 0, 0, 0, 4'b0100, 16'h0040);
        step("indep_add",  1,1,ADD,0, 8, 1, 2, 0, 0, 0, 0, 4'b1000, 16'h0040);
        step("mul7_st3",   1,1,MUL,0, 7, 1, 2, 0, 0, 0, 0, 4'b0100, 16'h0140);
        step("mul7_st4",   1,1,MUL,0, 7, 1, 2, 0, 0, 0, 0, 4'b0100, 16'h0140);
        step("mul7_go",    1,1,MUL,0, 7, 1, 2, 0, 0, 0, 0, 4'b1000, 16'h0140);
        step("redir_haz",  1,1,ADD,0, 2, 6, 1, 0, 0, 1, 0, 4'b0010, 16'h01C0);
        step("flush1",     1,1,ADD,0, 2, 6, 1, 0, 0, 0, 0, 4'b0010, 16'h01C0);
        step("flush2",     1,1,ADD,0, 2, 6, 1, 0, 0, 0, 0, 4'b0010, 16'h01C0);
        step("run_again",  1,0,ADD,0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 16'h01C0);
        step("wb6",        1,0,ADD,0, 0, 0, 0, 1, 6, 0, 0, 4'b0000, 16'h01C0);
        step("wb8",        1,0,ADD,0, 0, 0, 0, 1, 8, 0, 0, 4'b0000, 16'h0180);
        step("halt",       1,1,HLT,0, 0, 1, 2, 0, 0, 0, 0, 4'b1000, 16'h0080);
        step("halt_redir", 1,1,ADD,0, 1, 1, 2, 0, 0, 1, 0, 4'b0101, 16'h0080);
        step("halt_wb7",   1,0,ADD,0, 0, 0, 0, 1, 7, 0, 0, 4'b0101, 16'h0080);
        step("resume",     1,0,ADD,0, 0, 0, 0, 0, 0, 0, 1, 4'b0101, 16'h0000);
        step("run_res",    1,1,ADD,0, 3, 1, 2, 0, 0, 0, 0, 4'b1000, 16'h0000);
        step("add7",       1,1,ADD,0, 7, 1, 2, 0, 0, 0, 0, 4'b1000, 16'h0008);
        step("redir2",     1,0,ADD,0, 0, 0, 0, 0, 0, 1, 0, 4'b0010, 16'h0088);
        step("fl_reload",  1,0,ADD,0, 0, 0, 0, 0, 0, 1, 0, 4'b0010, 16'h0088);
        step("fl_a",       1,0,ADD,0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 16'h0088);
        step("rst_mid",    0,1,ADD,0, 3, 1, 2, 0, 0, 0, 0, 4'b0000, 16'h0000);
        step("rst_hold",   0,1,ADD,0, 3, 1, 2, 0, 0, 0, 0, 4'b0000, 16'h0000);
        step("post_rst",   1,1,ADD,0, 3, 1, 2, 0, 0, 0, 0, 4'b1000, 16'h0000);
        step("wb_nonbusy", 1,0,ADD,0, 0, 0, 0, 1, 9, 0, 0, 4'b0000, 16'h0008);
        step("set_clr",    1,1,ADD,0, 3, 1, 2, 1, 3, 0, 0, 4'b1000, 16'h0008);
        step("set_wins",   1,0,ADD,0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 16'h0008);
        step("branch",     1,1,BRA,0, 3, 3, 3, 0, 0, 0, 0, 4'b1000, 16'h0008);
        step("br_noset",   1,0,ADD,0, 0, 0, 0, 1, 3, 0, 0, 4'b0000, 16'h0008);
        step("final",      1,0,ADD,0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 16'h0000);

        for (int i = 0; i < 10; i++) begin
            if (expq.size() == 0) break;
            @(posedge clk);
        end
        checks++;
        if (expq.size() != 0)
            $display("FAIL drain: got %0d pending want 0", expq.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
